// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL responder backed by a word-addressed RAM.
// Each request is executed on acceptance and its response waits in a 2-entry in-order queue.
module tl_ul_ram_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned SOURCE_W = 10,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                auto_in_a_valid,
  output logic                auto_in_a_ready,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [1:0]          auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
  input  logic [11:0]         auto_in_a_bits_address,
  input  logic [3:0]          auto_in_a_bits_mask,
  input  logic [31:0]         auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_size,
  output logic [SOURCE_W-1:0] auto_in_d_bits_source,
  output logic                auto_in_d_bits_denied,
  output logic [31:0]         auto_in_d_bits_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  QCNT = 2'(QDEPTH);

  typedef enum logic [2:0] {
    OP_PUT_FULL    = 3'd0,
    OP_PUT_PARTIAL = 3'd1,
    OP_GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    D_ACK      = 3'd0,
    D_ACK_DATA = 3'd1
  } d_op_e;

  typedef struct packed {
    d_op_e               opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [31:0]         data;
  } rsp_t;

  logic [31:0] mem [DEPTH];

  rsp_t       q_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;

  logic       a_fire, d_fire;
  logic [9:0] idx;
  logic [AW-1:0] ram_idx;
  logic       in_range, op_ok, is_get;
  logic       we;
  rsp_t       rsp_d;
  rsp_t       head;

  logic unused_param;
  assign unused_param = ^auto_in_a_bits_param;

  assign idx      = auto_in_a_bits_address[11:2];
  assign ram_idx  = idx[AW-1:0];
  assign in_range = ({1'b0, idx} < 11'(DEPTH));
  assign is_get   = (auto_in_a_bits_opcode == OP_GET);
  assign op_ok    = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                    (auto_in_a_bits_opcode == OP_PUT_PARTIAL) || is_get;

  assign auto_in_a_ready = (count_q < QCNT);
  assign a_fire          = auto_in_a_valid && auto_in_a_ready;
  assign d_fire          = auto_in_d_valid && auto_in_d_ready;

  // Classification in priority order: bad opcode, out of range, poisoned put, then normal access
  always_comb begin
    rsp_d        = '0;
    rsp_d.size   = auto_in_a_bits_size;
    rsp_d.source = auto_in_a_bits_source;
    we           = 1'b0;
    if (!op_ok) begin
      rsp_d.opcode = D_ACK;
      rsp_d.denied = 1'b1;
    end else if (!in_range) begin
      rsp_d.opcode = is_get ? D_ACK_DATA : D_ACK;
      rsp_d.denied = 1'b1;
    end else if (!is_get && auto_in_a_bits_corrupt) begin
      rsp_d.opcode = D_ACK;
      rsp_d.denied = 1'b1;
    end else if (is_get) begin
      rsp_d.opcode = D_ACK_DATA;
      rsp_d.data   = mem[ram_idx];
    end else begin
      rsp_d.opcode = D_ACK;
      we           = a_fire;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (auto_in_a_bits_mask[i]) mem[ram_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({a_fire, d_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q[0]   <= '0;
      q_q[1]   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (a_fire) begin
        q_q[wr_ptr_q] <= rsp_d;
        wr_ptr_q      <= ~wr_ptr_q;
      end
      if (d_fire) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign head            = q_q[rd_ptr_q];
  assign auto_in_d_valid = (count_q != 2'd0);

  always_comb begin
    auto_in_d_bits_opcode = '0;
    auto_in_d_bits_size   = '0;
    auto_in_d_bits_source = '0;
    auto_in_d_bits_denied = 1'b0;
    auto_in_d_bits_data   = '0;
    if (auto_in_d_valid) begin
      auto_in_d_bits_opcode = head.opcode;
      auto_in_d_bits_size   = head.size;
      auto_in_d_bits_source = head.source;
      auto_in_d_bits_denied = head.denied;
      auto_in_d_bits_data   = head.data;
    end
  end

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Scoreboard bench for tl_ul_ram_responder: a reference RAM model predicts each response at
// acceptance, and a monitor checks the D channel and queue occupancy every cycle.
module tb_tl_ul_ram_responder;

  localparam int unsigned DEPTH    = 256;
  localparam int unsigned SOURCE_W = 10;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [31:0]         data;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                a_valid = 1'b0;
  logic                a_ready;
  logic [2:0]          a_opcode = '0;
  logic [2:0]          a_param = '0;
  logic [1:0]          a_size = '0;
  logic [SOURCE_W-1:0] a_source = '0;
  logic [11:0]         a_address = '0;
  logic [3:0]          a_mask = '0;
  logic [31:0]         a_data = '0;
  logic                a_corrupt = 1'b0;
  logic                d_ready = 1'b1;
  logic                d_valid;
  logic [2:0]          d_opcode;
  logic [1:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_denied;
  logic [31:0]         d_data;

  int   n_cmp = 0;
  int   n_err = 0;
  int   occ   = 0;
  bit   rand_dr = 1'b0;
  exp_t exp_q[$];
  bit [31:0] mdl [DEPTH];

  tl_ul_ram_responder #(.DEPTH(DEPTH), .SOURCE_W(SOURCE_W), .QDEPTH(2)) dut (
    .clock                  (clk),
    .reset                  (rst),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: returns the expected response and applies any write to the model RAM
  function automatic exp_t model(input logic [2:0] op, input logic [11:0] addr, input logic [3:0] mask,
                                 input logic [31:0] data, input logic [1:0] size,
                                 input logic [SOURCE_W-1:0] src, input logic corr);
    exp_t r;
    int unsigned w;
    w = int'(addr) / 4;
    r = '{opcode: 3'd0, size: size, source: src, denied: 1'b0, data: 32'd0};
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) begin
      r.denied = 1'b1;
    end else if (w >= DEPTH) begin
      r.opcode = (op == 3'd4) ? 3'd1 : 3'd0;
      r.denied = 1'b1;
    end else if (op != 3'd4 && corr) begin
      r.denied = 1'b1;
    end else if (op == 3'd4) begin
      r.opcode = 3'd1;
      r.data   = mdl[w];
    end else begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) mdl[w][8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic [1:0] size,
                      input logic [SOURCE_W-1:0] src, input logic corr);
    bit acc = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask;
    a_data = data; a_size = size; a_source = src; a_corrupt = corr;
    a_param = 3'($urandom_range(0, 7));
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      if (a_ready) begin
        exp_q.push_back(model(op, addr, mask, data, size, src, corr));
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL a_accept_timeout: got not accepted expected accepted at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    bit done = 1'b0;
    a_valid = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && occ == 0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: occupancy model, handshake levels, and in-order response comparison
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        occ = 0;
      end else begin
        chk("a_ready", a_ready, occ < 2);
        chk("d_valid", d_valid, occ != 0);
        if (d_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL d_unexpected: got response src %0h expected none", d_source);
          end else begin
            e = exp_q[0];
            chk("d_opcode", d_opcode, e.opcode);
            chk("d_size",   d_size,   e.size);
            chk("d_source", d_source, e.source);
            chk("d_denied", d_denied, e.denied);
            chk("d_data",   d_data,   e.data);
            if (d_ready) void'(exp_q.pop_front());
          end
        end
        occ = occ + int'(a_valid && a_ready) - int'(d_valid && d_ready);
        if (occ > 2 || occ < 0) chk("occupancy", 64'(occ), 64'd2);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_dr) d_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [2:0]  op;
    logic [11:0] addr;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_d_opcode", d_opcode, 3'd0);
    chk("rst_d_source", d_source, '0);
    chk("rst_d_denied", d_denied, 1'b0);
    chk("rst_d_data", d_data, 32'd0);
    rst = 1'b0;
    idle(2);

    // Give every RAM word a known value before any read
    for (int w = 0; w < DEPTH; w++)
      send(3'd0, 12'(w * 4), 4'hF, $urandom, 2'd2, 10'($urandom_range(0, 1023)), 1'b0);
    drain();

    send(3'd0, 12'h010, 4'hF, 32'hDEADBEEF, 2'd2, 10'd5, 1'b0);
    send(3'd4, 12'h010, 4'hF, 32'h0, 2'd2, 10'd7, 1'b0);
    send(3'd1, 12'h010, 4'h6, 32'h11223344, 2'd2, 10'd8, 1'b0);
    send(3'd4, 12'h010, 4'h1, 32'h0, 2'd1, 10'd9, 1'b0);
    drain();

    d_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send(3'd4, 12'(16 + 4 * i), 4'hF, 32'h0, 2'd2, 10'(20 + i), 1'b0);
        a_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_a_ready", a_ready, 1'b0);
        d_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 20; i++)
      send(3'd4, 12'($urandom_range(0, DEPTH - 1) * 4), 4'hF, 32'h0, 2'd2, 10'(100 + i), 1'b0);
    drain();

    send(3'd4, 12'h400, 4'hF, 32'h0, 2'd2, 10'd30, 1'b0);
    send(3'd2, 12'h010, 4'hF, 32'h12345678, 2'd2, 10'd31, 1'b0);
    send(3'd0, 12'h010, 4'hF, 32'hBADBAD00, 2'd2, 10'd32, 1'b1);
    send(3'd4, 12'h010, 4'hF, 32'h0, 2'd2, 10'd33, 1'b0);
    send(3'd0, 12'hFFC, 4'hF, 32'hCAFEF00D, 2'd2, 10'd34, 1'b0);
    drain();

    rand_dr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 3'd0;
        3, 4:    op = 3'd1;
        5, 6, 7, 8: op = 3'd4;
        default: op = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 9) == 0) addr = 12'($urandom);
      else addr = 12'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      send(op, addr, 4'($urandom), $urandom, 2'($urandom_range(0, 2)),
           10'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) begin
        a_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rand_dr = 1'b0;
    d_ready = 1'b1;
    drain();

    d_ready = 1'b0;
    send(3'd0, 12'h020, 4'hF, 32'hA5A5_0001, 2'd2, 10'd40, 1'b0);
    send(3'd0, 12'h024, 4'hF, 32'h5A5A_0002, 2'd2, 10'd41, 1'b0);
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_d_valid", d_valid, 1'b0);
    chk("mid_rst_a_ready", a_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    d_ready = 1'b1;
    idle(5);
    send(3'd4, 12'h020, 4'hF, 32'h0, 2'd2, 10'd42, 1'b0);
    send(3'd4, 12'h024, 4'hF, 32'h0, 2'd2, 10'd43, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
